// File: rtl/id_control.sv
// ID-stage control: instruction decode, ALU operand selection, branch
// operand forwarding muxes, branch resolution and a sticky halt flag.
module id_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic [31:0] regd1,
  input  logic [31:0] regd2,
  input  logic [1:0]  branch_a1_sel,
  input  logic [1:0]  branch_a2_sel,
  input  logic [31:0] branch_a1_EX,
  input  logic [31:0] branch_a1_MEM,
  input  logic [31:0] branch_a1_WB,
  input  logic [31:0] branch_a2_EX,
  input  logic [31:0] branch_a2_MEM,
  input  logic [31:0] branch_a2_WB,
  output logic [31:0] branch_a1,
  output logic [31:0] branch_a2,
  output logic [31:0] alu_1_data,
  output logic [31:0] alu_2_data,
  output logic [3:0]  alu_op,
  output logic        is_immd,
  output logic        only_shamt,
  output logic        mem_w,
  output logic        mem_r,
  output logic        wb_en,
  output logic        branch_taken,
  output logic        jump_taken,
  output logic        is_branch,
  output logic        is_jal,
  output logic        is_jr,
  output logic        terminate
);

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLL = 4'd7,
    ALU_SRL = 4'd8, ALU_SRA = 4'd9
  } alu_op_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] immd;

  assign op    = instruction[31:26];
  assign shamt = instruction[10:6];
  assign funct = instruction[5:0];
  assign immd  = instruction[15:0];

  alu_op_e dec_alu_op;
  logic dec_immd, dec_shamt, dec_mem_w, dec_mem_r, dec_wb;
  logic dec_jump, dec_branch, dec_beq, dec_jal, dec_jr, dec_term;
  logic branch_eq;

  // Forwarding muxes for branch comparator operands
  always_comb begin
    branch_a1 = regd1;
    branch_a2 = regd2;
    case (branch_a1_sel)
      2'd0: branch_a1 = regd1;
      2'd1: branch_a1 = branch_a1_EX;
      2'd2: branch_a1 = branch_a1_MEM;
      2'd3: branch_a1 = branch_a1_WB;
      default: branch_a1 = regd1;
    endcase
    case (branch_a2_sel)
      2'd0: branch_a2 = regd2;
      2'd1: branch_a2 = branch_a2_EX;
      2'd2: branch_a2 = branch_a2_MEM;
      2'd3: branch_a2 = branch_a2_WB;
      default: branch_a2 = regd2;
    endcase
  end

  assign branch_eq = (branch_a1 == branch_a2);

  // Raw instruction decode, independent of stall and halt
  always_comb begin
    dec_alu_op = ALU_ADD;
    dec_immd   = 1'b0;
    dec_shamt  = 1'b0;
    dec_mem_w  = 1'b0;
    dec_mem_r  = 1'b0;
    dec_wb     = 1'b0;
    dec_jump   = 1'b0;
    dec_branch = 1'b0;
    dec_beq    = 1'b0;
    dec_jal    = 1'b0;
    dec_jr     = 1'b0;
    dec_term   = 1'b0;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100000, 6'b100001: begin dec_alu_op = ALU_ADD; dec_wb = 1'b1; end
          6'b100010, 6'b100011: begin dec_alu_op = ALU_SUB; dec_wb = 1'b1; end
          6'b100100: begin dec_alu_op = ALU_AND; dec_wb = 1'b1; end
          6'b100101: begin dec_alu_op = ALU_OR;  dec_wb = 1'b1; end
          6'b100110: begin dec_alu_op = ALU_XOR; dec_wb = 1'b1; end
          6'b100111: begin dec_alu_op = ALU_NOR; dec_wb = 1'b1; end
          6'b101010: begin dec_alu_op = ALU_SLT; dec_wb = 1'b1; end
          6'b000000: begin dec_alu_op = ALU_SLL; dec_shamt = 1'b1; dec_wb = 1'b1; end
          6'b000010: begin dec_alu_op = ALU_SRL; dec_shamt = 1'b1; dec_wb = 1'b1; end
          6'b000011: begin dec_alu_op = ALU_SRA; dec_shamt = 1'b1; dec_wb = 1'b1; end
          6'b000100: begin dec_alu_op = ALU_SLL; dec_wb = 1'b1; end
          6'b000110: begin dec_alu_op = ALU_SRL; dec_wb = 1'b1; end
          6'b000111: begin dec_alu_op = ALU_SRA; dec_wb = 1'b1; end
          6'b001000: begin dec_jr = 1'b1; dec_jump = 1'b1; end
          default: ;
        endcase
      end
      6'b001000, 6'b001001: begin dec_alu_op = ALU_ADD; dec_immd = 1'b1; dec_wb = 1'b1; end
      6'b001100: begin dec_alu_op = ALU_AND; dec_immd = 1'b1; dec_wb = 1'b1; end
      6'b001101: begin dec_alu_op = ALU_OR;  dec_immd = 1'b1; dec_wb = 1'b1; end
      6'b001110: begin dec_alu_op = ALU_XOR; dec_immd = 1'b1; dec_wb = 1'b1; end
      6'b100011: begin dec_immd = 1'b1; dec_mem_r = 1'b1; dec_wb = 1'b1; end
      6'b101011: begin dec_immd = 1'b1; dec_mem_w = 1'b1; end
      6'b000100: begin dec_branch = 1'b1; dec_beq = 1'b1; end
      6'b000101: begin dec_branch = 1'b1; end
      6'b000010: begin dec_jump = 1'b1; end
      6'b000011: begin dec_jump = 1'b1; dec_jal = 1'b1; dec_wb = 1'b1; end
      6'b111111: begin dec_term = 1'b1; end
      default: ;
    endcase
  end

  // Halt state register; rst clears it asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  // Halt next state and final flag gating (halt overrides stall overrides decode)
  always_comb begin
    state_d      = state_q;
    alu_op       = ALU_ADD;
    is_immd      = dec_immd;
    only_shamt   = dec_shamt;
    mem_w        = 1'b0;
    mem_r        = 1'b0;
    wb_en        = 1'b0;
    branch_taken = 1'b0;
    jump_taken   = 1'b0;
    is_branch    = 1'b0;
    is_jal       = 1'b0;
    is_jr        = 1'b0;
    terminate    = 1'b0;
    if (state_q == ST_RUN && dec_term && !stall) state_d = ST_HALT;
    if (state_q == ST_HALT) begin
      is_immd    = 1'b0;
      only_shamt = 1'b0;
      terminate  = 1'b1;
    end else if (!stall) begin
      alu_op       = dec_alu_op;
      mem_w        = dec_mem_w;
      mem_r        = dec_mem_r;
      wb_en        = dec_wb;
      branch_taken = dec_branch & (dec_beq ? branch_eq : ~branch_eq);
      jump_taken   = dec_jump;
      is_branch    = dec_branch;
      is_jal       = dec_jal;
      is_jr        = dec_jr;
      terminate    = dec_term;
    end
  end

  // ALU operand muxes follow the (possibly halt-gated) flags
  assign alu_1_data = only_shamt ? {27'd0, shamt} : regd1;
  assign alu_2_data = is_immd ? {{16{immd[15]}}, immd} : regd2;

endmodule

// File: tb/tb_id_control.sv
// Directed bench for id_control: decode flags, operand muxes, branch
// resolution, stall gating and the sticky halt flag.
module tb_id_control;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic        stall;
  logic [31:0] regd1, regd2;
  logic [1:0]  branch_a1_sel, branch_a2_sel;
  logic [31:0] branch_a1_EX, branch_a1_MEM, branch_a1_WB;
  logic [31:0] branch_a2_EX, branch_a2_MEM, branch_a2_WB;
  logic [31:0] branch_a1, branch_a2, alu_1_data, alu_2_data;
  logic [3:0]  alu_op;
  logic is_immd, only_shamt, mem_w, mem_r, wb_en;
  logic branch_taken, jump_taken, is_branch, is_jal, is_jr, terminate;

  int checks = 0;
  int errors = 0;

  // flag vector order: is_immd only_shamt mem_w mem_r wb_en br_taken jump is_branch is_jal is_jr terminate
  logic [10:0] flags;
  assign flags = {is_immd, only_shamt, mem_w, mem_r, wb_en, branch_taken,
                  jump_taken, is_branch, is_jal, is_jr, terminate};

  id_control dut (
    .clk(clk), .rst(rst), .instruction(instruction), .stall(stall),
    .regd1(regd1), .regd2(regd2),
    .branch_a1_sel(branch_a1_sel), .branch_a2_sel(branch_a2_sel),
    .branch_a1_EX(branch_a1_EX), .branch_a1_MEM(branch_a1_MEM), .branch_a1_WB(branch_a1_WB),
    .branch_a2_EX(branch_a2_EX), .branch_a2_MEM(branch_a2_MEM), .branch_a2_WB(branch_a2_WB),
    .branch_a1(branch_a1), .branch_a2(branch_a2),
    .alu_1_data(alu_1_data), .alu_2_data(alu_2_data), .alu_op(alu_op),
    .is_immd(is_immd), .only_shamt(only_shamt), .mem_w(mem_w), .mem_r(mem_r),
    .wb_en(wb_en), .branch_taken(branch_taken), .jump_taken(jump_taken),
    .is_branch(is_branch), .is_jal(is_jal), .is_jr(is_jr), .terminate(terminate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; instruction = 32'h00221820;
    regd1 = 32'd5; regd2 = 32'd7;
    branch_a1_sel = 2'd0; branch_a2_sel = 2'd0;
    branch_a1_EX = 32'd0; branch_a1_MEM = 32'd0; branch_a1_WB = 32'd0;
    branch_a2_EX = 32'd0; branch_a2_MEM = 32'd0; branch_a2_WB = 32'd0;
    @(posedge clk); #1;
    checks++; if (flags !== 11'b00001000000) begin errors++; $display("FAIL reset_flags got %b want %b", flags, 11'b00001000000); end
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (terminate !== 1'b0) begin errors++; $display("FAIL reset_term got %b want 0", terminate); end
  endtask

  task automatic test_rtype();
    instruction = 32'h00221820; regd1 = 32'd5; regd2 = 32'd7; #1;
    checks++; if (alu_op !== 4'd0) begin errors++; $display("FAIL add_op got %0d want 0", alu_op); end
    checks++; if (flags !== 11'b00001000000) begin errors++; $display("FAIL add_flags got %b want %b", flags, 11'b00001000000); end
    checks++; if (alu_1_data !== 32'd5 || alu_2_data !== 32'd7) begin errors++; $display("FAIL add_data got %0d,%0d want 5,7", alu_1_data, alu_2_data); end
    instruction = 32'h00000022; #1;
    checks++; if (alu_op !== 4'd1) begin errors++; $display("FAIL sub_op got %0d want 1", alu_op); end
    instruction = 32'h0000002A; #1;
    checks++; if (alu_op !== 4'd6) begin errors++; $display("FAIL slt_op got %0d want 6", alu_op); end
    instruction = 32'h00000027; #1;
    checks++; if (alu_op !== 4'd5) begin errors++; $display("FAIL nor_op got %0d want 5", alu_op); end
    instruction = 32'h00000001; #1;
    checks++; if (flags !== 11'b0 || alu_op !== 4'd0) begin errors++; $display("FAIL bad_funct got %b op %0d want 0 op 0", flags, alu_op); end
    instruction = 32'h00000008; #1;
    checks++; if (flags !== 11'b00000010010 || alu_op !== 4'd0) begin errors++; $display("FAIL jr got %b op %0d want %b op 0", flags, alu_op, 11'b00000010010); end
  endtask

  task automatic test_shift();
    instruction = 32'h00000100; regd1 = 32'd9; regd2 = 32'd3; #1;
    checks++; if (alu_op !== 4'd7) begin errors++; $display("FAIL sll_op got %0d want 7", alu_op); end
    checks++; if (flags !== 11'b01001000000) begin errors++; $display("FAIL sll_flags got %b want %b", flags, 11'b01001000000); end
    checks++; if (alu_1_data !== 32'd4 || alu_2_data !== 32'd3) begin errors++; $display("FAIL sll_data got %0d,%0d want 4,3", alu_1_data, alu_2_data); end
    instruction = 32'h00000107; #1;
    checks++; if (alu_op !== 4'd9 || only_shamt !== 1'b0 || alu_1_data !== 32'd9) begin errors++; $display("FAIL srav got op %0d sh %b a1 %0d want 9 0 9", alu_op, only_shamt, alu_1_data); end
    instruction = 32'h00000142; #1;
    checks++; if (alu_op !== 4'd8 || alu_1_data !== 32'd5) begin errors++; $display("FAIL srl got op %0d a1 %0d want 8 5", alu_op, alu_1_data); end
  endtask

  task automatic test_immd_mem();
    regd2 = 32'd7;
    instruction = 32'h2000FFFE; #1;
    checks++; if (flags !== 11'b10001000000 || alu_op !== 4'd0) begin errors++; $display("FAIL addi_flags got %b op %0d want %b op 0", flags, alu_op, 11'b10001000000); end
    checks++; if (alu_2_data !== 32'hFFFFFFFE) begin errors++; $display("FAIL addi_data got %h want fffffffe", alu_2_data); end
    instruction = 32'h30008001; #1;
    checks++; if (alu_op !== 4'd2 || alu_2_data !== 32'hFFFF8001) begin errors++; $display("FAIL andi got op %0d d %h want 2 ffff8001", alu_op, alu_2_data); end
    instruction = 32'h8C000004; #1;
    checks++; if (flags !== 11'b10011000000 || alu_2_data !== 32'd4) begin errors++; $display("FAIL lw got %b d %h want %b d 4", flags, alu_2_data, 11'b10011000000); end
    instruction = 32'hAC000008; #1;
    checks++; if (flags !== 11'b10100000000) begin errors++; $display("FAIL sw got %b want %b", flags, 11'b10100000000); end
    instruction = 32'hF0000000; #1;
    checks++; if (flags !== 11'b0 || alu_op !== 4'd0) begin errors++; $display("FAIL bad_op got %b op %0d want 0 op 0", flags, alu_op); end
  endtask

  task automatic test_branch();
    regd1 = 32'd0; regd2 = 32'd1;
    branch_a1_sel = 2'd1; branch_a1_EX = 32'd9;
    branch_a2_sel = 2'd3; branch_a2_WB = 32'd9;
    instruction = 32'h10000000; #1;
    checks++; if (flags !== 11'b00000101000) begin errors++; $display("FAIL beq_eq got %b want %b", flags, 11'b00000101000); end
    branch_a2_WB = 32'd8; #1;
    checks++; if (flags !== 11'b00000001000) begin errors++; $display("FAIL beq_ne got %b want %b", flags, 11'b00000001000); end
    instruction = 32'h14000000; #1;
    checks++; if (branch_taken !== 1'b1) begin errors++; $display("FAIL bne_ne got %b want 1", branch_taken); end
    branch_a1_EX = 32'h80000008; #1;
    checks++; if (branch_taken !== 1'b1) begin errors++; $display("FAIL bne_msb got %b want 1", branch_taken); end
    branch_a1_sel = 2'd2; branch_a1_MEM = 32'h1234;
    branch_a2_sel = 2'd0; regd2 = 32'h1234; #1;
    checks++; if (branch_a1 !== 32'h1234 || branch_a2 !== 32'h1234 || branch_taken !== 1'b0) begin errors++; $display("FAIL mux_mem got %h,%h t %b want 1234,1234 t 0", branch_a1, branch_a2, branch_taken); end
    branch_a1_sel = 2'd0; branch_a2_sel = 2'd2; branch_a2_MEM = 32'h55; #1;
    checks++; if (branch_a1 !== 32'd0 || branch_a2 !== 32'h55) begin errors++; $display("FAIL mux_sel got %h,%h want 0,55", branch_a1, branch_a2); end
  endtask

  task automatic test_jump_stall();
    instruction = 32'h08000000; stall = 1'b0; #1;
    checks++; if (flags !== 11'b00000010000) begin errors++; $display("FAIL j got %b want %b", flags, 11'b00000010000); end
    instruction = 32'h0C000000; stall = 1'b1; #1;
    checks++; if (flags !== 11'b0) begin errors++; $display("FAIL jal_stall got %b want 0", flags); end
    stall = 1'b0; #1;
    checks++; if (flags !== 11'b00001010100) begin errors++; $display("FAIL jal got %b want %b", flags, 11'b00001010100); end
    instruction = 32'h2000FFFE; stall = 1'b1; #1;
    checks++; if (flags !== 11'b10000000000 || alu_2_data !== 32'hFFFFFFFE) begin errors++; $display("FAIL addi_stall got %b d %h want %b d fffffffe", flags, alu_2_data, 11'b10000000000); end
    instruction = 32'h00000022; #1;
    checks++; if (alu_op !== 4'd0) begin errors++; $display("FAIL sub_stall_op got %0d want 0", alu_op); end
    stall = 1'b0;
  endtask

  task automatic test_halt();
    @(negedge clk);
    instruction = 32'hFC000000; stall = 1'b1;
    @(posedge clk); #1;
    instruction = 32'h00221820; stall = 1'b0; #1;
    checks++; if (flags !== 11'b00001000000) begin errors++; $display("FAIL term_stalled got %b want %b", flags, 11'b00001000000); end
    @(negedge clk);
    instruction = 32'hFC000000; #1;
    checks++; if (flags !== 11'b00000000001) begin errors++; $display("FAIL term_dec got %b want %b", flags, 11'b00000000001); end
    @(posedge clk); #1;
    instruction = 32'h00221820; #1;
    checks++; if (flags !== 11'b00000000001 || alu_op !== 4'd0) begin errors++; $display("FAIL halt_hold got %b op %0d want %b op 0", flags, alu_op, 11'b00000000001); end
    @(posedge clk); #1;
    instruction = 32'h0C000000; #1;
    checks++; if (flags !== 11'b00000000001) begin errors++; $display("FAIL halt_jal got %b want %b", flags, 11'b00000000001); end
    instruction = 32'h00221820;
    @(negedge clk); #2;
    rst = 1'b0; #1;
    checks++; if (terminate !== 1'b0 || wb_en !== 1'b1) begin errors++; $display("FAIL async_rst got t %b wb %b want 0 1", terminate, wb_en); end
    #1 rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (flags !== 11'b00001000000) begin errors++; $display("FAIL post_rst got %b want %b", flags, 11'b00001000000); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_shift();
    test_immd_mem();
    test_branch();
    test_jump_stall();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_control.md
ID_CONTROL -- requirements
Module: id_control

Interface
REQ-001 clk  in  1  sole clock; halt flag samples on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 instruction  in  32  ID-stage instruction: op=[31:26], shamt=[10:6], funct=[5:0], immd=[15:0].
REQ-004 stall  in  1  hazard bubble request.
REQ-005 regd1, regd2  in  32 each  register-file rs/rt values.
REQ-006 branch_a1_sel, branch_a2_sel  in  2 each  comparator operand source select.
REQ-007 branch_a1_EX/MEM/WB, branch_a2_EX/MEM/WB  in  32 each  forwarded operand values.
REQ-008 branch_a1, branch_a2  out  32 each  selected comparator operands.
REQ-009 alu_1_data, alu_2_data  out  32 each  ALU operands.
REQ-010 alu_op  out  4  ALU operation code.
REQ-011 is_immd, only_shamt, mem_w, mem_r, wb_en  out  1 each  decode flags.
REQ-012 branch_taken, jump_taken, is_branch, is_jal, is_jr, terminate  out  1 each  flow-control flags.

Function
REQ-013 Operand muxes (data_mux_4): sel 0 -> regdN, 1 -> EX, 2 -> MEM, 3 -> WB; purely combinational.
REQ-014 alu_2_data (data_mux): is_immd ? sign_extend(immd) : regd2; all I-type immediates sign-extended, including andi/ori/xori.
REQ-015 alu_1_data (data_mux): only_shamt ? zero_extend(shamt) : regd1.
REQ-016 alu_op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLL, 8 SRL, 9 SRA; 10-15 unused.
REQ-017 R-type (op 000000) funct: 100000/100001 ADD; 100010/100011 SUB; 100100 AND; 100101 OR; 100110 XOR; 100111 NOR; 101010 SLT; wb_en=1.
REQ-018 sll 000000 / srl 000010 / sra 000011: SLL/SRL/SRA, only_shamt=1, wb_en=1; sllv 000100 / srlv 000110 / srav 000111: same alu_op, only_shamt=0.
REQ-019 jr (funct 001000): is_jr=1, jump_taken=1, wb_en=0, alu_op ADD.
REQ-020 addi 001000 / addiu 001001 ADD; andi 001100 AND; ori 001101 OR; xori 001110 XOR; all is_immd=1, wb_en=1.
REQ-021 lw 100011: ADD, is_immd, mem_r, wb_en; sw 101011: ADD, is_immd, mem_w, wb_en=0.
REQ-022 beq 000100 / bne 000101: is_branch=1, wb_en=0; branch_taken = (branch_a1==branch_a2) for beq, (!=) for bne, full 32-bit compare.
REQ-023 j 000010: jump_taken=1; jal 000011: jump_taken=1, is_jal=1, wb_en=1.
REQ-024 op 111111: terminate=1, all other flags 0.
REQ-025 Undefined op or R-type funct: all flags 0, alu_op ADD (bubble).
REQ-026 stall=1: mem_w, mem_r, wb_en, branch_taken, jump_taken, is_branch, is_jal, is_jr, terminate forced 0, alu_op ADD; data muxes unaffected.
REQ-027 Halt flag: set on rising clk when decoded terminate=1 and stall=0; once set, terminate output held 1 and all other flags forced 0 until reset.
REQ-028 All outputs except halt flag are combinational; zero-cycle latency from any input.

Reset
REQ-029 rst low clears halt flag immediately (asynchronous), regardless of clk.
REQ-030 After reset, outputs follow pure decode of current inputs; no other state exists.

Verification
REQ-031 instr add $3,$1,$2 (0x00221820), regd1=5, regd2=7 -> alu_op 0, wb_en 1, alu_1=5, alu_2=7, is_immd 0.
REQ-032 sll shamt=4, regd2=3 -> alu_op 7, only_shamt 1, alu_1=4, alu_2=3.
REQ-033 addi immd=0xFFFE -> is_immd 1, alu_2=0xFFFFFFFE; lw -> mem_r 1; sw -> mem_w 1, wb_en 0.
REQ-034 beq, sel1=1 (EX=9), sel2=3 (WB=9), regd1=0 -> branch_taken 1; change WB to 8 -> 0; bne with same -> 1.
REQ-035 jal with stall=1 -> all flags 0; stall=0 -> jump_taken 1, is_jal 1, wb_en 1.
REQ-036 op 111111, clock edge -> terminate stays 1 after instruction changes to add; rst low mid-cycle -> terminate 0 immediately.
